collision_scanner: RTL

COLLISION_SCANNER -- requirements
Module: collision_scanner

---
 rtl/collision_scanner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/collision_scanner.sv
// Collision scanner: tests one reference sprite against every sprite in the register file.
// Optional macro COLLISION_FIRST_HIT_STOP_EN ends the scan at the first qualified hit.
module collision_scanner #(
   parameter int N_SPRITES = 32,
   parameter int ADDR_W    = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    ref_index,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [31:0]          rd_data,
   output logic [31:0]          cmp_register,
   output logic [31:0]          cmp_data,
   input  logic                 cmp_result,
   output logic                 busy,
   output logic                 done,
   output logic                 hit,
   output logic [ADDR_W-1:0]    hit_index,
   output logic [N_SPRITES-1:0] hit_mask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REF_FETCH,
      S_REF_LATCH,
      S_FETCH,
      S_LATCH,
      S_EVAL,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SPRITES - 1);
   localparam int                EN_BIT   = 29;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      ref_idx_q, ref_idx_d;
   logic [ADDR_W-1:0]      i_q, i_d;
   logic [31:0]            ref_word_q, ref_word_d;
   logic [31:0]            cand_q, cand_d;
   logic                   hit_q, hit_d;
   logic [ADDR_W-1:0]      hit_index_q, hit_index_d;
   logic [N_SPRITES-1:0]   hit_mask_q, hit_mask_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
   logic                   qual_hit;

   // A disabled reference or candidate, or the reference meeting itself, never counts.
   assign qual_hit = cmp_result & cand_q[EN_BIT] & ref_word_q[EN_BIT] & (i_q != ref_idx_q);

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a latch.
      state_d     = state_q;
      ref_idx_d   = ref_idx_q;
      i_d         = i_q;
      ref_word_d  = ref_word_q;
      cand_d      = cand_q;
      hit_d       = hit_q;
      hit_index_d = hit_index_q;
      hit_mask_d  = hit_mask_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_REF_FETCH;
               ref_idx_d   = ref_index;
               i_d         = '0;
               hit_d       = 1'b0;
               hit_index_d = '0;
               hit_mask_d  = '0;
            end
         end
         S_REF_FETCH: state_d = S_REF_LATCH;
         S_REF_LATCH: begin
            ref_word_d = rd_data;
            state_d    = S_FETCH;
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            cand_d  = rd_data;
            state_d = S_EVAL;
         end
         S_EVAL: begin
            if (qual_hit) begin
               hit_mask_d[i_q] = 1'b1;
               hit_d           = 1'b1;
               if (!hit_q) hit_index_d = i_q;
            end
`ifdef COLLISION_FIRST_HIT_STOP_EN
            if (qual_hit || i_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               i_d     = i_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
`else
            if (i_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               i_d     = i_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered: derive them from the state being entered.
      busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d    = (state_d == S_DONE);
      rd_addr_d = (state_d == S_REF_FETCH) ? ref_idx_d :
                  (state_d == S_FETCH)     ? i_d       : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         ref_idx_q   <= '0;
         i_q         <= '0;
         ref_word_q  <= '0;
         cand_q      <= '0;
         hit_q       <= 1'b0;
         hit_index_q <= '0;
         hit_mask_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         ref_idx_q   <= ref_idx_d;
         i_q         <= i_d;
         ref_word_q  <= ref_word_d;
         cand_q      <= cand_d;
         hit_q       <= hit_d;
         hit_index_q <= hit_index_d;
         hit_mask_q  <= hit_mask_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_addr_q   <= rd_addr_d;
      end
   end

   assign rd_addr      = rd_addr_q;
   assign cmp_register = ref_word_q;
   assign cmp_data     = cand_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign hit          = hit_q;
   assign hit_index    = hit_index_q;
   assign hit_mask     = hit_mask_q;

endmodule
